// File: rtl/gpio_msg_link.sv
// gpio_msg_link: framed full-duplex serial message link over GPIO pins.
// Define GPIO_MSG_LINK_PARITY_EN to append an even-parity bit per frame.
module gpio_msg_link #(
  parameter int MSG_BITS    = 128,
  parameter int DIV         = 50,
  parameter int ACK_TIMEOUT = 16,
  parameter int ACK_HOLD    = 2
) (
  input  logic                clock,
  input  logic                RESETN,
  input  logic                send,
  input  logic [MSG_BITS-1:0] tx_message,
  output logic                busy,
  output logic                done,
  output logic                tx_error,
  output logic                tx_line,
  output logic                tx_sclk,
  output logic                tx_frame,
  input  logic                ack_in,
  input  logic                rx_line,
  input  logic                rx_sclk,
  input  logic                rx_frame,
  output logic                ack_out,
  output logic [MSG_BITS-1:0] rx_message,
  output logic                rx_valid,
  output logic                rx_error
);

`ifdef GPIO_MSG_LINK_PARITY_EN
  localparam int NB = MSG_BITS + 1;
`else
  localparam int NB = MSG_BITS;
`endif
  localparam int TMO = ACK_TIMEOUT * DIV;
  localparam int HLD = ACK_HOLD * DIV;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(NB + 2);
  localparam int TW  = $clog2(TMO + 1);
  localparam int HW  = $clog2(HLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_ACK
  } tx_state_t;

  tx_state_t     state;
  logic [NB-1:0] tx_word;
  logic [NB-1:0] tx_sr;
  logic [BW-1:0] tx_bit;
  logic [CW-1:0] tx_cyc;
  logic [CW-1:0] cyc_nx;
  logic [TW-1:0] tx_tmr;

  logic [1:0] ack_sy;
  logic [1:0] line_sy;
  logic [1:0] sclk_sy;
  logic [1:0] frame_sy;
  logic       ack_s;
  logic       line_s;
  logic       sclk_s;
  logic       frame_s;
  logic       sclk_d;
  logic       frame_d;

  logic [NB-1:0] rx_sr;
  logic [BW-1:0] rx_cnt;
  logic [HW-1:0] ack_tmr;
  logic          rx_good;

`ifdef GPIO_MSG_LINK_PARITY_EN
  assign tx_word = {^tx_message, tx_message};
  assign rx_good = (rx_cnt == BW'(NB)) && !(^rx_sr);
`else
  assign tx_word = tx_message;
  assign rx_good = (rx_cnt == BW'(NB));
`endif

  assign cyc_nx  = tx_cyc + 1'b1;
  assign ack_s   = ack_sy[1];
  assign line_s  = line_sy[1];
  assign sclk_s  = sclk_sy[1];
  assign frame_s = frame_sy[1];

  always_ff @(posedge clock or negedge RESETN) begin
    if (!RESETN) begin
      ack_sy   <= '0;
      line_sy  <= '0;
      sclk_sy  <= '0;
      frame_sy <= '0;
    end else begin
      ack_sy   <= {ack_sy[0], ack_in};
      line_sy  <= {line_sy[0], rx_line};
      sclk_sy  <= {sclk_sy[0], rx_sclk};
      frame_sy <= {frame_sy[0], rx_frame};
    end
  end

  // send is blocked during the done/tx_error pulse cycle
  always_ff @(posedge clock or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_error <= 1'b0;
      tx_line  <= 1'b0;
      tx_sclk  <= 1'b0;
      tx_frame <= 1'b0;
      tx_sr    <= '0;
      tx_bit   <= '0;
      tx_cyc   <= '0;
      tx_tmr   <= '0;
    end else begin
      done     <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send && !done && !tx_error) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            tx_sr    <= tx_word;
            tx_line  <= tx_word[0];
            tx_sclk  <= 1'b0;
            tx_frame <= 1'b1;
            tx_bit   <= '0;
            tx_cyc   <= '0;
          end
        end
        SHIFT: begin
          if (tx_cyc == CW'(DIV - 1)) begin
            tx_cyc  <= '0;
            tx_sclk <= 1'b0;
            if (tx_bit == BW'(NB - 1)) begin
              state    <= WAIT_ACK;
              tx_frame <= 1'b0;
              tx_line  <= 1'b0;
              tx_tmr   <= '0;
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              tx_sr   <= tx_sr >> 1;
              tx_line <= tx_sr[1];
            end
          end else begin
            tx_cyc  <= cyc_nx;
            tx_sclk <= (cyc_nx >= CW'(DIV / 2));
          end
        end
        WAIT_ACK: begin
          if (ack_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tx_tmr == TW'(TMO - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_error <= 1'b1;
          end else begin
            tx_tmr <= tx_tmr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge RESETN) begin
    if (!RESETN) begin
      sclk_d     <= 1'b0;
      frame_d    <= 1'b0;
      rx_sr      <= '0;
      rx_cnt     <= '0;
      ack_tmr    <= '0;
      ack_out    <= 1'b0;
      rx_message <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      frame_d  <= frame_s;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (ack_out) begin
        if (ack_tmr == HW'(HLD - 1))
          ack_out <= 1'b0;
        else
          ack_tmr <= ack_tmr + 1'b1;
      end
      if (frame_d && !frame_s) begin
        rx_cnt <= '0;
        if (rx_good) begin
          rx_message <= rx_sr[MSG_BITS-1:0];
          rx_valid   <= 1'b1;
          ack_out    <= 1'b1;
          ack_tmr    <= '0;
        end else begin
          rx_error <= 1'b1;
        end
      end else if (frame_s && sclk_s && !sclk_d) begin
        rx_sr <= {line_s, rx_sr[NB-1:1]};
        if (rx_cnt != BW'(NB + 1))
          rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpio_msg_link.sv
// tb_gpio_msg_link: directed checks of gpio_msg_link with switchable loopback.
// Parity scenario runs only when GPIO_MSG_LINK_PARITY_EN is defined.
module tb_gpio_msg_link;
  localparam int MB = 16;
  localparam int DV = 4;
`ifdef GPIO_MSG_LINK_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = (MB + PB) * DV;

  logic clock = 1'b0;
  logic RESETN = 1'b0;
  logic send = 1'b0;
  logic [MB-1:0] tx_message = '0;
  logic busy, done, tx_error, tx_line, tx_sclk, tx_frame;
  logic ack_in, rx_line, rx_sclk, rx_frame, ack_out;
  logic [MB-1:0] rx_message;
  logic rx_valid, rx_error;

  logic lb_ack = 1'b1;
  logic lb_rx = 1'b1;
  logic drv_line = 1'b0;
  logic drv_sclk = 1'b0;
  logic drv_frame = 1'b0;

  int checks = 0;
  int errors = 0;

  assign ack_in   = lb_ack ? ack_out : 1'b0;
  assign rx_line  = lb_rx ? tx_line : drv_line;
  assign rx_sclk  = lb_rx ? tx_sclk : drv_sclk;
  assign rx_frame = lb_rx ? tx_frame : drv_frame;

  always #5 clock = ~clock;

  gpio_msg_link #(
    .MSG_BITS(MB), .DIV(DV), .ACK_TIMEOUT(4), .ACK_HOLD(2)
  ) dut (
    .clock(clock), .RESETN(RESETN), .send(send),
    .tx_message(tx_message), .busy(busy), .done(done),
    .tx_error(tx_error), .tx_line(tx_line), .tx_sclk(tx_sclk),
    .tx_frame(tx_frame), .ack_in(ack_in), .rx_line(rx_line),
    .rx_sclk(rx_sclk), .rx_frame(rx_frame), .ack_out(ack_out),
    .rx_message(rx_message), .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  // Sends one message and measures the frame and the handshake after it.
  task automatic xfer(input logic [MB-1:0] msg, output int flen,
                      output logic [MB:0] bits, output int sbad,
                      output int nval, output int ndone,
                      output int nack, output int nerr,
                      output logic [MB-1:0] got);
    int n;
    flen = 0; bits = '0; sbad = 0; nval = 0;
    ndone = 0; nack = 0; nerr = 0; got = '0;
    tx_message = msg;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    n = 0;
    while (tx_frame === 1'b1 && n < 300) begin
      if (n % DV == DV / 2 && n / DV <= MB) bits[n/DV] = tx_line;
      if (tx_sclk !== ((n % DV) >= DV / 2)) sbad++;
      n++;
      @(negedge clock);
    end
    flen = n;
    for (int i = 0; i < 40; i++) begin
      if (rx_valid === 1'b1) begin nval++; got = rx_message; end
      if (done === 1'b1) ndone++;
      if (ack_out === 1'b1) nack++;
      if (tx_error === 1'b1) nerr++;
      @(negedge clock);
    end
  endtask

  task automatic drive_rx(input logic [MB:0] word, input int nbits);
    drv_frame = 1'b1; drv_sclk = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      drv_line = word[i]; drv_sclk = 1'b0;
      repeat (2) @(negedge clock);
      drv_sclk = 1'b1;
      repeat (2) @(negedge clock);
    end
    drv_sclk = 1'b0;
    repeat (2) @(negedge clock);
    drv_frame = 1'b0; drv_line = 1'b0;
  endtask

  task automatic test_reset();
    logic [MB+8:0] outs;
    repeat (2) @(negedge clock);
    outs = {busy, done, tx_error, tx_line, tx_sclk, tx_frame,
            ack_out, rx_valid, rx_error, rx_message};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outs got %h want 0", outs);
    end
    RESETN = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_loopback();
    int fl, sb, nv, nd, na, ne;
    logic [MB:0] b;
    logic [MB-1:0] g;
    xfer(16'hA53C, fl, b, sb, nv, nd, na, ne, g);
    checks++;
    if (fl != FRAME) begin errors++; $display("FAIL lb_len got %0d want %0d", fl, FRAME); end
    checks++;
    if (b[MB-1:0] !== 16'hA53C) begin errors++; $display("FAIL lb_bits got %h want a53c", b[MB-1:0]); end
    checks++;
    if (sb != 0) begin errors++; $display("FAIL lb_sclk got %0d bad phases want 0", sb); end
    checks++;
    if (nv != 1) begin errors++; $display("FAIL lb_valid got %0d want 1", nv); end
    checks++;
    if (g !== 16'hA53C) begin errors++; $display("FAIL lb_rxmsg got %h want a53c", g); end
    checks++;
    if (na != 2 * DV) begin errors++; $display("FAIL lb_ack got %0d want %0d", na, 2 * DV); end
    checks++;
    if (nd != 1 || ne != 0) begin errors++; $display("FAIL lb_done got %0d/%0d want 1/0", nd, ne); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL lb_busy got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int n, first, nerr, nd;
    lb_ack = 1'b0;
    tx_message = 16'h1234;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    n = 0;
    while (tx_frame === 1'b1 && n < 300) begin n++; @(negedge clock); end
    first = -1; nerr = 0; nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (tx_error === 1'b1) begin nerr++; if (first < 0) first = k; end
      if (done === 1'b1) nd++;
      @(negedge clock);
    end
    checks++;
    if (first != 16) begin errors++; $display("FAIL to_delay got %0d want 16", first); end
    checks++;
    if (nerr != 1) begin errors++; $display("FAIL to_count got %0d want 1", nerr); end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL to_done got %0d want 0", nd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b want 0", busy); end
    lb_ack = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [MB-1:0] msgs [4];
    int nv, nd, rises, gap;
    logic fprev;
    nv = 0; nd = 0; rises = 0; gap = 0; fprev = 1'b0;
    tx_message = 16'h1111;
    send = 1'b1;
    for (int c = 0; c < 350; c++) begin
      @(negedge clock);
      if (c == 10) tx_message = 16'h2222;
      if (c == 200) send = 1'b0;
      if (rx_valid === 1'b1) begin
        if (nv < 4) msgs[nv] = rx_message;
        nv++;
      end
      if (done === 1'b1) nd++;
      if (tx_frame === 1'b1 && !fprev) rises++;
      if (rises == 1 && tx_frame === 1'b0 && busy === 1'b0) gap++;
      fprev = tx_frame;
    end
    checks++;
    if (nv != 3 || nd != 3) begin errors++; $display("FAIL b2b_count got %0d/%0d want 3/3", nv, nd); end
    checks++;
    if (msgs[0] !== 16'h1111) begin errors++; $display("FAIL b2b_first got %h want 1111", msgs[0]); end
    checks++;
    if (msgs[1] !== 16'h2222) begin errors++; $display("FAIL b2b_second got %h want 2222", msgs[1]); end
    checks++;
    if (gap != 2) begin errors++; $display("FAIL b2b_idle_gap got %0d want 2", gap); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask

  task automatic test_short_frame();
    int ne, nv, na;
    lb_rx = 1'b0;
    ne = 0; nv = 0; na = 0;
    drive_rx(17'h0_0F0F, 12);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (rx_error === 1'b1) ne++;
      if (rx_valid === 1'b1) nv++;
      if (ack_out === 1'b1) na++;
    end
    checks++;
    if (ne != 1) begin errors++; $display("FAIL short_err got %0d want 1", ne); end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL short_valid got %0d want 0", nv); end
    checks++;
    if (na != 0) begin errors++; $display("FAIL short_ack got %0d want 0", na); end
    checks++;
    if (rx_message !== 16'h2222) begin errors++; $display("FAIL short_keep got %h want 2222", rx_message); end
    lb_rx = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [MB+8:0] outs;
    int ev, fl, sb, nv, nd, na, ne;
    logic [MB:0] b;
    logic [MB-1:0] g;
    tx_message = 16'h00FF;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    repeat (30) @(negedge clock);
    RESETN = 1'b0;
    #1;
    outs = {busy, done, tx_error, tx_line, tx_sclk, tx_frame,
            ack_out, rx_valid, rx_error, rx_message};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rst_mid_outs got %h want 0", outs); end
    @(negedge clock);
    RESETN = 1'b1;
    ev = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done === 1'b1 || rx_valid === 1'b1) ev++;
      if (tx_error === 1'b1 || rx_error === 1'b1) ev++;
    end
    checks++;
    if (ev != 0) begin errors++; $display("FAIL rst_mid_events got %0d want 0", ev); end
    xfer(16'hC3A5, fl, b, sb, nv, nd, na, ne, g);
    checks++;
    if (fl != FRAME) begin errors++; $display("FAIL rst_next_len got %0d want %0d", fl, FRAME); end
    checks++;
    if (nv != 1 || g !== 16'hC3A5) begin errors++; $display("FAIL rst_next_msg got %h n=%0d want c3a5", g, nv); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL rst_next_done got %0d want 1", nd); end
  endtask

`ifdef GPIO_MSG_LINK_PARITY_EN
  task automatic test_parity();
    int fl, sb, nv, nd, na, ne, rerr;
    logic [MB:0] b;
    logic [MB-1:0] g;
    xfer(16'h0001, fl, b, sb, nv, nd, na, ne, g);
    checks++;
    if (fl != 68) begin errors++; $display("FAIL par_len got %0d want 68", fl); end
    checks++;
    if (b[MB] !== 1'b1) begin errors++; $display("FAIL par_bit got %b want 1", b[MB]); end
    checks++;
    if (nv != 1 || g !== 16'h0001) begin errors++; $display("FAIL par_valid got %h n=%0d want 0001", g, nv); end
    lb_rx = 1'b0;
    rerr = 0; nv = 0; na = 0;
    drive_rx(17'h0_0001, 17);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (rx_error === 1'b1) rerr++;
      if (rx_valid === 1'b1) nv++;
      if (ack_out === 1'b1) na++;
    end
    checks++;
    if (rerr != 1 || nv != 0 || na != 0) begin
      errors++;
      $display("FAIL par_bad got err=%0d valid=%0d ack=%0d want 1/0/0", rerr, nv, na);
    end
    lb_rx = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_timeout();
    test_back_to_back();
    test_short_frame();
    test_reset_mid();
`ifdef GPIO_MSG_LINK_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_msg_link.md
Name: gpio_msg_link

Overview:
- Parametrised successor to the single-width GPIO message protocol: a full-duplex, framed, serial message transceiver between two FPGAs over GPIO pins.
- Generalised in message width, bit rate and ack timeout; adds an acknowledge handshake with timeout, received-frame length checking and error reporting.
- Sits between the application (LCD/keyboard message registers) and the GPIO header.
- Runs on one fast clock. The bit clock comes from an internal divider; no separate slow clock domain.

Parameters:
- MSG_BITS, 128, message width in bits (multiple of 8, ≥8).
- DIV, 50, clock cycles per bit period (even, ≥4).
- ACK_TIMEOUT, 16, bit periods to wait for ack_in after a frame ends.
- ACK_HOLD, 2, bit periods ack_out is held high after a good receive.

Ports:
- clock  in  1  system clock; all logic on its rising edge
- RESETN  in  1  asynchronous active-low reset
- send  in  1  request to transmit tx_message (level or pulse)
- tx_message  in  MSG_BITS  message to send; byte 0 in bits [7:0]
- busy  out  1  TX FSM not in IDLE
- done  out  1  one-cycle pulse: far end acknowledged
- tx_error  out  1  one-cycle pulse: ack timeout
- tx_line  out  1  serial data to GPIO
- tx_sclk  out  1  bit strobe to GPIO
- tx_frame  out  1  high while a frame is on the wire
- ack_in  in  1  ack from far end (asynchronous)
- rx_line, rx_sclk, rx_frame  in  1 each  far-end serial inputs (asynchronous)
- ack_out  out  1  ack to far end
- rx_message  out  MSG_BITS  last good received message
- rx_valid  out  1  one-cycle pulse: rx_message updated
- rx_error  out  1  one-cycle pulse: bad frame discarded

Behaviour:
- Reset (RESETN low, asynchronous): all outputs 0, rx_message 0, FSMs IDLE, counters and synchronisers cleared. Any partial TX or RX frame is abandoned with no done, valid or error pulse.
- All asynchronous inputs (ack_in, rx_*) pass through 2-flop synchronisers before use.
- TX FSM states and transitions:
  - IDLE→SHIFT: send=1 while in IDLE. tx_message is captured on that edge; later changes are ignored.
  - send is ignored in every state other than IDLE, including the cycle done/tx_error pulses.
  - SHIFT: tx_frame=1 from the cycle after acceptance. Bits go LSB-first (bit 0 first). Each bit is held on tx_line for DIV cycles. tx_sclk is 0 for the first DIV/2 cycles of a bit period and 1 for the last DIV/2. Frame length is MSG_BITS×DIV cycles.
  - SHIFT→WAIT_ACK: after the last bit period. tx_frame, tx_line and tx_sclk go to 0.
  - WAIT_ACK→IDLE on synchronised ack_in=1: done pulses 1 cycle.
  - WAIT_ACK→IDLE after ACK_TIMEOUT×DIV cycles without ack_in: tx_error pulses 1 cycle. If ack_in and timeout coincide, ack wins.
  - busy = (state ≠ IDLE).
- RX:
  - On each synchronised rx_sclk rising edge while synchronised rx_frame=1, shift rx_line into a staging register (LSB-first) and increment the bit count.
  - The bit count saturates at MSG_BITS+1 (+2 with parity).
  - On rx_frame falling with count=MSG_BITS: rx_message ← staging, rx_valid pulses, ack_out=1 for ACK_HOLD×DIV cycles.
  - On rx_frame falling with any other count: rx_error pulses, rx_message unchanged, no ack.
  - A new frame starting while ack_out is still high is received normally. ack_out keeps its own timer.
- TX and RX are independent. Loopback (tx→rx, ack_out→ack_in) must work.

Optional Feature:
- Macro: GPIO_MSG_LINK_PARITY_EN.
- When defined:
  - TX appends one even-parity bit (XOR of all message bits) after bit MSG_BITS-1. Frame is (MSG_BITS+1)×DIV cycles.
  - RX requires count=MSG_BITS+1 and a matching parity bit. On mismatch: rx_error pulses, no rx_valid, no ack.
- When undefined: no parity bit, and frame and RX checks are exactly as in Behaviour.

Test Plan (bench MSG_BITS=16, DIV=4, ACK_TIMEOUT=4, ACK_HOLD=2, loopback wired):
- send=1 one cycle, tx_message=16'hA53C → tx_frame high 64 cycles; tx_line bit sequence 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1; rx_valid pulse with rx_message=16'hA53C; ack_out high 8 cycles; done pulses once; busy low after.
- ack_in tied 0, send 16'h1234 → tx_error pulses exactly 16 cycles after tx_frame falls; no done; busy returns 0.
- send held high for 200 cycles with tx_message changing mid-frame → first frame carries the value captured at acceptance; a second frame starts only after IDLE is reached.
- Drive rx_frame with only 12 rx_sclk edges → rx_error pulse; rx_message keeps its previous value; ack_out stays 0.
- RESETN low for 1 cycle at bit 7 of a frame → all outputs 0 immediately; no done, valid or error; next send transmits a complete, correct frame.
- With GPIO_MSG_LINK_PARITY_EN: 16'h0001 sent → parity bit 1, frame 68 cycles, rx_valid. Then inject a flipped parity bit on rx_line → rx_error pulse, no ack.
